// File: rtl/inst_fetcher_pkg.sv
// Shared types and constants for the instruction fetcher and its queue.
// Includes FSM encoding, queue entry layout and RVC length decode.
package inst_fetcher_pkg;

    localparam int          IQ_SIZE   = 8;
    localparam int          IQ_SIZE_W = 3;
    localparam logic [31:0] RESET_PC  = 32'h0;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_WAIT = 2'd1,
        IF_DROP = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } iq_entry_t;

    // Low two bits 2'b11 mark a full 32-bit instruction; anything else is RVC.
    function automatic logic [31:0] inst_len(input logic [1:0] lo);
        return (lo == 2'b11) ? 32'd4 : 32'd2;
    endfunction

endpackage

// File: rtl/inst_fetcher_if.sv
// Icache, decoder and predictor signals seen by the fetcher.
// master = fetcher side, slave = icache/decoder/predictor side.
interface inst_fetcher_if;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_ready;
    logic        ic_valid;
    logic [31:0] ic_data;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        dec_ready;
    logic        need_branch;
    logic [31:0] branch_addr;
    logic        predict_fail;
    logic [31:0] fail_addr;

    modport master (
        output ic_req, ic_addr, inst_valid, inst_out, inst_pc,
        input  ic_ready, ic_valid, ic_data, dec_ready,
               need_branch, branch_addr, predict_fail, fail_addr
    );

    modport slave (
        input  ic_req, ic_addr, inst_valid, inst_out, inst_pc,
        output ic_ready, ic_valid, ic_data, dec_ready,
               need_branch, branch_addr, predict_fail, fail_addr
    );
endinterface

// File: rtl/inst_queue.sv
// Circular FIFO of {pc, inst} pairs with flush; head is shown combinationally.
// Caller guarantees no push when full without a pop, and no pop when empty.
module inst_queue
    import inst_fetcher_pkg::*;
#(
    parameter int DEPTH   = IQ_SIZE,
    parameter int DEPTH_W = IQ_SIZE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  iq_entry_t        i_data,
    output logic [DEPTH_W:0] o_count,
    output logic             o_valid,
    output iq_entry_t        o_head
);

    iq_entry_t          r_mem [DEPTH];
    logic [DEPTH_W-1:0] r_wr;
    logic [DEPTH_W-1:0] r_rd;
    logic [DEPTH_W:0]   r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (i_pop)  r_rd <= r_rd + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: nothing is visible until count is nonzero.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr] <= i_data;
    end

    assign o_count = r_count;
    assign o_valid = (r_count != '0);
    assign o_head  = o_valid ? r_mem[r_rd] : '0;

endmodule

// File: rtl/inst_fetcher.sv
// PC generator with a single outstanding icache fetch feeding an instruction queue.
// Predictor redirects flush the queue and discard any in-flight fetch.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = inst_fetcher_pkg::RESET_PC,
    parameter int          IQ_DEPTH   = IQ_SIZE,
    parameter int          IQ_DEPTH_W = IQ_SIZE_W
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    inst_fetcher_if.master     bus
);

    localparam logic [IQ_DEPTH_W:0] LP_FULL = (IQ_DEPTH_W + 1)'(IQ_DEPTH);

    if_state_e            r_state;
    logic [31:0]          r_pc;

    logic                 w_redirect;
    logic [31:0]          w_target;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_req;
    logic                 w_hs;
    logic                 w_resp;
    logic [IQ_DEPTH_W:0]  w_count;
    logic                 w_iq_valid;
    iq_entry_t            w_head;
    iq_entry_t            w_push_data;

    assign w_redirect = rdy_in && (bus.predict_fail || bus.need_branch);
    assign w_target   = (bus.predict_fail ? bus.fail_addr : bus.branch_addr) & ~32'h1;
    assign w_pop      = rdy_in && w_iq_valid && bus.dec_ready;
    assign w_resp     = rdy_in && bus.ic_valid;
    assign w_push     = w_resp && (r_state == IF_WAIT) && !w_redirect;

    // A pop this cycle frees the slot the next response will need.
    assign w_req = !rst_in && rdy_in && (r_state == IF_IDLE) && ((w_count != LP_FULL) || w_pop);
    assign w_hs  = w_req && bus.ic_ready;

    assign w_push_data = '{pc: r_pc, inst: bus.ic_data};

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= IF_IDLE;
            r_pc    <= RESET_PC;
        end else if (rdy_in) begin
            case (r_state)
                IF_IDLE: if (w_hs) r_state <= w_redirect ? IF_DROP : IF_WAIT;
                IF_WAIT: begin
                    if (w_redirect)  r_state <= w_resp ? IF_IDLE : IF_DROP;
                    else if (w_resp) r_state <= IF_IDLE;
                end
                IF_DROP: if (w_resp) r_state <= IF_IDLE;
                default: r_state <= IF_IDLE;
            endcase
            if (w_redirect)  r_pc <= w_target;
            else if (w_push) r_pc <= r_pc + inst_len(bus.ic_data[1:0]);
        end
    end

    inst_queue #(
        .DEPTH   (IQ_DEPTH),
        .DEPTH_W (IQ_DEPTH_W)
    ) u_queue (
        .clk     (clk_in),
        .rst     (rst_in),
        .i_push  (w_push),
        .i_pop   (w_pop && !w_redirect),
        .i_flush (w_redirect),
        .i_data  (w_push_data),
        .o_count (w_count),
        .o_valid (w_iq_valid),
        .o_head  (w_head)
    );

    assign bus.ic_req     = w_req;
    assign bus.ic_addr    = w_req ? r_pc : '0;
    assign bus.inst_valid = w_iq_valid;
    assign bus.inst_out   = w_head.inst;
    assign bus.inst_pc    = w_head.pc;

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher: fetch stream, RVC lengths, redirects,
// full-queue backpressure with wrap, rdy_in freeze and async reset.
module tb_inst_fetcher;

    logic clk;
    logic rst;
    logic rdy;
    int   n_checks;
    int   n_errors;

    inst_fetcher_if bus ();

    inst_fetcher dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .bus    (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One request/response pair from IDLE with a 1-cycle icache.
    task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] data);
        chk("req", {31'd0, bus.ic_req}, 32'd1);
        chk("addr", bus.ic_addr, exp_addr);
        cyc();
        bus.ic_valid = 1'b1;
        bus.ic_data  = data;
        #1;
        chk("wait_noreq", {31'd0, bus.ic_req}, 32'd0);
        cyc();
        bus.ic_valid = 1'b0;
        bus.ic_data  = 32'h0;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        rdy = 1'b0;
        bus.ic_ready     = 1'b0;
        bus.ic_valid     = 1'b0;
        bus.ic_data      = 32'h0;
        bus.dec_ready    = 1'b0;
        bus.need_branch  = 1'b0;
        bus.branch_addr  = 32'h0;
        bus.predict_fail = 1'b0;
        bus.fail_addr    = 32'h0;
        #1;
        chk("rst_req",   {31'd0, bus.ic_req}, 32'd0);
        chk("rst_addr",  bus.ic_addr, 32'h0);
        chk("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
        chk("rst_inst",  bus.inst_out, 32'h0);
        chk("rst_pc",    bus.inst_pc, 32'h0);
        cyc();
        rst = 1'b0;
        rdy = 1'b1;
        bus.ic_ready = 1'b1;
        #1;

        // Sequential 32-bit fetches
        fetch(32'h0, 32'h00000013);
        chk("t1_valid", {31'd0, bus.inst_valid}, 32'd1);
        fetch(32'h4, 32'h00000013);
        fetch(32'h8, 32'h00000013);
        bus.ic_ready  = 1'b0;
        bus.dec_ready = 1'b1;
        #1;
        chk("t1_pc0", bus.inst_pc, 32'h0);
        chk("t1_in0", bus.inst_out, 32'h00000013);
        cyc();
        chk("t1_pc1", bus.inst_pc, 32'h4);
        cyc();
        chk("t1_pc2", bus.inst_pc, 32'h8);
        cyc();
        chk("t1_empty", {31'd0, bus.inst_valid}, 32'd0);
        bus.dec_ready = 1'b0;

        // Mixed RVC from pc 0
        bus.predict_fail = 1'b1;
        bus.fail_addr    = 32'h0;
        cyc();
        bus.predict_fail = 1'b0;
        bus.ic_ready     = 1'b1;
        #1;
        fetch(32'h0, 32'hABCD0001);
        fetch(32'h2, 32'h00000013);
        chk("t2_next", bus.ic_addr, 32'h6);
        chk("t2_pc0", bus.inst_pc, 32'h0);
        chk("t2_in0", bus.inst_out, 32'hABCD0001);
        bus.ic_ready  = 1'b0;
        bus.dec_ready = 1'b1;
        cyc();
        chk("t2_pc1", bus.inst_pc, 32'h2);
        cyc();
        chk("t2_empty", {31'd0, bus.inst_valid}, 32'd0);
        bus.dec_ready = 1'b0;
        bus.ic_ready  = 1'b1;
        #1;

        // need_branch while WAIT, stale response dropped
        fetch(32'h6, 32'h00000013);
        cyc();
        chk("t3_wait", {31'd0, bus.ic_req}, 32'd0);
        bus.need_branch = 1'b1;
        bus.branch_addr = 32'h100;
        cyc();
        bus.need_branch = 1'b0;
        bus.branch_addr = 32'h0;
        #1;
        chk("t3_flush", {31'd0, bus.inst_valid}, 32'd0);
        chk("t3_drop",  {31'd0, bus.ic_req}, 32'd0);
        bus.ic_valid = 1'b1;
        bus.ic_data  = 32'h00000013;
        cyc();
        bus.ic_valid = 1'b0;
        #1;
        chk("t3_nopush", {31'd0, bus.inst_valid}, 32'd0);
        chk("t3_req",    {31'd0, bus.ic_req}, 32'd1);
        chk("t3_addr",   bus.ic_addr, 32'h100);

        // predict_fail beats need_branch
        fetch(32'h100, 32'h00000013);
        bus.ic_ready     = 1'b0;
        bus.predict_fail = 1'b1;
        bus.fail_addr    = 32'h40;
        bus.need_branch  = 1'b1;
        bus.branch_addr  = 32'h80;
        bus.dec_ready    = 1'b1;
        cyc();
        bus.predict_fail = 1'b0;
        bus.need_branch  = 1'b0;
        bus.dec_ready    = 1'b0;
        #1;
        chk("t4_flush", {31'd0, bus.inst_valid}, 32'd0);
        chk("t4_addr",  bus.ic_addr, 32'h40);
        bus.ic_ready = 1'b1;
        #1;

        // Fill to 8, backpressure, one pop -> one request, wrap order
        for (int i = 0; i < 8; i++)
            fetch(32'h40 + 32'(4 * i), 32'h00000013 | (32'(i) << 20));
        chk("t5_full",  {31'd0, bus.ic_req}, 32'd0);
        cyc();
        chk("t5_hold",  {31'd0, bus.ic_req}, 32'd0);
        bus.dec_ready = 1'b1;
        #1;
        chk("t5_popreq", {31'd0, bus.ic_req}, 32'd1);
        chk("t5_paddr",  bus.ic_addr, 32'h60);
        cyc();
        bus.dec_ready = 1'b0;
        #1;
        chk("t5_wait", {31'd0, bus.ic_req}, 32'd0);
        bus.ic_valid = 1'b1;
        bus.ic_data  = 32'h00800013;
        cyc();
        bus.ic_valid = 1'b0;
        #1;
        chk("t5_refull", {31'd0, bus.ic_req}, 32'd0);
        cyc();
        chk("t5_refull2", {31'd0, bus.ic_req}, 32'd0);
        bus.ic_ready  = 1'b0;
        bus.dec_ready = 1'b1;
        #1;
        for (int i = 1; i <= 8; i++) begin
            chk("t5_wpc",  bus.inst_pc, 32'h40 + 32'(4 * i));
            chk("t5_winst", bus.inst_out, 32'h00000013 | (32'(i) << 20));
            cyc();
        end
        chk("t5_empty", {31'd0, bus.inst_valid}, 32'd0);
        bus.dec_ready = 1'b0;
        bus.ic_ready  = 1'b1;
        #1;

        // rdy_in freeze mid-WAIT
        fetch(32'h64, 32'h00000013);
        cyc();
        rdy = 1'b0;
        bus.dec_ready   = 1'b1;
        bus.need_branch = 1'b1;
        bus.branch_addr = 32'h200;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t6_fvalid", {31'd0, bus.inst_valid}, 32'd1);
            chk("t6_fpc",    bus.inst_pc, 32'h64);
            chk("t6_freq",   {31'd0, bus.ic_req}, 32'd0);
            cyc();
        end
        rdy = 1'b1;
        bus.dec_ready   = 1'b0;
        bus.need_branch = 1'b0;
        bus.ic_valid    = 1'b1;
        bus.ic_data     = 32'h00000013;
        cyc();
        bus.ic_valid = 1'b0;
        #1;
        chk("t6_req",  {31'd0, bus.ic_req}, 32'd1);
        chk("t6_addr", bus.ic_addr, 32'h6C);
        chk("t6_head", bus.inst_pc, 32'h64);

        // Async reset between edges
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rreq",   {31'd0, bus.ic_req}, 32'd0);
        chk("t6_raddr",  bus.ic_addr, 32'h0);
        chk("t6_rvalid", {31'd0, bus.inst_valid}, 32'd0);
        chk("t6_rinst",  bus.inst_out, 32'h0);
        chk("t6_rpc",    bus.inst_pc, 32'h0);
        cyc();
        rst = 1'b0;
        #1;
        chk("t6_pcreq",  {31'd0, bus.ic_req}, 32'd1);
        chk("t6_pcaddr", bus.ic_addr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
